boot_cfg_loader: RTL
====================

BOOT_CFG_LOADER -- requirements
Module: boot_cfg_loader

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 2, number of config bytes read from SRAM (range 1..8).
REQ-002 SHALL have parameter BASE_ADDR, default 19'h08FD5, SRAM address of config byte 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, SRAM settle cycles before capture (range 1..15).
REQ-004 SHALL have parameter DEFAULT_CFG, default all zeros, width 8*NUM_BYTES, used when checksum fails.
REQ-005 SHALL have ports: clk_sys  in  1  system clock (the only clock).
REQ-006 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have: reload  in  1  request re-read of config; sampled only in DONE.
REQ-008 SHALL have: sram_data_i  in  8  SRAM data bus read value.
REQ-009 SHALL have: core_sram_addr  in  19  core address; core_sram_we  in  1  core write enable (1 = write).
REQ-010 SHALL have: sram_addr  out  19; sram_we  out  1  (1 = write); muxed SRAM controls.
REQ-011 SHALL have: cfg_out  out  8*NUM_BYTES  byte i in bits [8i+7:8i]; cfg_valid  out  1; cfg_err  out  1.
REQ-012 SHALL have: core_reset_n  out  1  registered active-low reset to the machine core.

Function
REQ-013 SHALL implement states WAIT, CAPTURE, DONE (plus CHECK when CFG_CHECKSUM_EN is defined), and a byte index idx (3 bits) and settle counter cnt (4 bits).
REQ-014 In WAIT and CAPTURE, sram_addr SHALL equal BASE_ADDR+idx (19-bit wrap) and sram_we SHALL be 0, regardless of core inputs.
REQ-015 In DONE, sram_addr SHALL equal core_sram_addr and sram_we SHALL equal core_sram_we, combinationally.
REQ-016 WAIT SHALL hold for exactly WAIT_CYCLES cycles (cnt counts down to 1), then go to CAPTURE.
REQ-017 CAPTURE SHALL last one cycle, latch sram_data_i into byte idx of a shadow register; if idx = NUM_BYTES-1, go to DONE (or CHECK), else idx+1, reload cnt, go to WAIT.
REQ-018 Load time SHALL be NUM_BYTES*(WAIT_CYCLES+1) cycles from reset release or reload to DONE entry (without checksum).
REQ-019 On DONE entry, shadow SHALL be copied to cfg_out and cfg_valid set to 1 in the same edge; cfg_out SHALL be stable outside that edge.
REQ-020 core_reset_n SHALL be 0 in all states except DONE, and rise on the first clock after DONE entry.
REQ-021 reload=1 in DONE SHALL: clear cfg_valid, drive core_reset_n 0, idx=0, cnt=WAIT_CYCLES, enter WAIT on the next edge; cfg_out SHALL keep the previous value until the new load completes.
REQ-022 reload while not in DONE SHALL be ignored.
REQ-023 core_sram_* activity during load SHALL have no effect on sram_addr, sram_we or captured data.

Reset
REQ-024 On reset_n=0, asynchronously: state=WAIT, idx=0, cnt=WAIT_CYCLES, shadow=0, cfg_out=DEFAULT_CFG, cfg_valid=0, cfg_err=0, core_reset_n=0.
REQ-025 Reset asserted mid-load or in DONE SHALL abort immediately and restart the full load after release.
REQ-026 sram_addr SHALL equal BASE_ADDR and sram_we 0 while reset_n=0.

Configuration
REQ-027 Macro BOOT_CFG_CHECKSUM_EN defined: one extra byte SHALL be read at BASE_ADDR+NUM_BYTES (same WAIT/CAPTURE timing), then one CHECK cycle; if it equals XOR of all config bytes XOR 8'hA5, cfg_out=shadow and cfg_err=0, else cfg_out=DEFAULT_CFG and cfg_err=1; cfg_valid=1 either way; load time becomes (NUM_BYTES+1)*(WAIT_CYCLES+1)+1.
REQ-028 Macro undefined: no CHECK state, no extra read, cfg_err tied 0.

Verification
REQ-029 NUM_BYTES=2, WAIT_CYCLES=2, SRAM model returns 8'h01 at 19'h08FD5, 8'h3C at 19'h08FD6; release reset -> cfg_out=16'h3C01, cfg_valid=1 after 6 cycles, core_reset_n=1 one cycle later.
REQ-030 During that load toggle core_sram_we=1, core_sram_addr=19'h00000 -> sram_we stays 0, sram_addr only 08FD5/08FD6; after DONE sram_addr follows core_sram_addr same cycle.
REQ-031 In DONE change SRAM byte 0 to 8'hFE, pulse reload 1 cycle -> core_reset_n 0 and cfg_valid 0 next cycle, cfg_out holds 16'h3C01 until 6 cycles later becomes 16'h3CFE.
REQ-032 Assert reset_n=0 at cycle 3 of a load -> outputs return to REQ-024 values asynchronously; after release full 6-cycle load repeats.
REQ-033 With BOOT_CFG_CHECKSUM_EN, bytes 01,3C, checksum byte 8'h98 -> cfg_err=0, cfg_out=16'h3C01 after 10 cycles; checksum byte 8'h00 -> cfg_err=1, cfg_out=DEFAULT_CFG.
REQ-034 reload held 1 continuously from reset -> ignored during load, triggers exactly one restart per DONE entry.

Source files
------------

// File: rtl/boot_cfg_loader.sv
// Boot config loader: reads config bytes from SRAM, then releases the core.
// BOOT_CFG_CHECKSUM_EN adds a checksum byte read and a CHECK state.
module boot_cfg_loader #(
  parameter int          NUM_BYTES   = 2,
  parameter logic [18:0] BASE_ADDR   = 19'h08FD5,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [8*NUM_BYTES-1:0] DEFAULT_CFG = '0
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   reload,
  input  logic [7:0]             sram_data_i,
  input  logic [18:0]            core_sram_addr,
  input  logic                   core_sram_we,
  output logic [18:0]            sram_addr,
  output logic                   sram_we,
  output logic [8*NUM_BYTES-1:0] cfg_out,
  output logic                   cfg_valid,
  output logic                   cfg_err,
  output logic                   core_reset_n
);
  localparam int         CW   = 8*NUM_BYTES;
  localparam logic [3:0] WC   = 4'(WAIT_CYCLES);
  localparam logic [2:0] LAST = 3'(NUM_BYTES-1);

`ifdef BOOT_CFG_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_WAIT, S_CAPTURE, S_DONE, S_CHECK
  } state_t;
`else
  typedef enum logic [1:0] {
    S_WAIT, S_CAPTURE, S_DONE
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic [CW-1:0] cfg_new;
  logic [18:0]   rd_off;
  logic          cap;
  logic          load_done;

`ifdef BOOT_CFG_CHECKSUM_EN
  logic       ck_q, ck_d;
  logic       cap_ck;
  logic [7:0] ck_byte_q;
  logic [7:0] sum;
  logic       err_new;

  always_comb begin
    sum = 8'hA5;
    for (int i = 0; i < NUM_BYTES; i++)
      sum = sum ^ shadow_q[8*i +: 8];
  end

  assign err_new = (sum != ck_byte_q);
  assign cfg_new = err_new ? DEFAULT_CFG : shadow_q;
  assign rd_off  = ck_q ? 19'(NUM_BYTES)
                        : {16'd0, idx_q};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ck_q      <= 1'b0;
      ck_byte_q <= 8'h00;
      cfg_err   <= 1'b0;
    end else begin
      ck_q <= ck_d;
      if (cap_ck) ck_byte_q <= sram_data_i;
      if (load_done) cfg_err <= err_new;
    end
  end
`else
  assign cfg_new = shadow_d;
  assign rd_off  = {16'd0, idx_q};
  assign cfg_err = 1'b0;
`endif

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_BYTES; i++)
      if (cap && idx_q == 3'(i))
        shadow_d[8*i +: 8] = sram_data_i;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    cap       = 1'b0;
    load_done = 1'b0;
`ifdef BOOT_CFG_CHECKSUM_EN
    ck_d   = ck_q;
    cap_ck = 1'b0;
`endif
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q <= 4'd1) state_d = S_CAPTURE;
        else cnt_d = cnt_q - 4'd1;
      end
      S_CAPTURE: begin
        state_d = S_WAIT;
        cnt_d   = WC;
`ifdef BOOT_CFG_CHECKSUM_EN
        if (ck_q) begin
          cap_ck  = 1'b1;
          state_d = S_CHECK;
        end else begin
          cap = 1'b1;
          if (idx_q == LAST) ck_d = 1'b1;
          else idx_d = idx_q + 3'd1;
        end
`else
        cap = 1'b1;
        if (idx_q == LAST) begin
          state_d   = S_DONE;
          load_done = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
`endif
      end
`ifdef BOOT_CFG_CHECKSUM_EN
      S_CHECK: begin
        state_d   = S_DONE;
        load_done = 1'b1;
      end
`endif
      S_DONE: begin
        if (reload) begin
          state_d = S_WAIT;
          idx_d   = 3'd0;
          cnt_d   = WC;
`ifdef BOOT_CFG_CHECKSUM_EN
          ck_d = 1'b0;
`endif
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_WAIT;
      idx_q        <= 3'd0;
      cnt_q        <= WC;
      shadow_q     <= '0;
      cfg_out      <= DEFAULT_CFG;
      cfg_valid    <= 1'b0;
      core_reset_n <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      core_reset_n <= (state_q == S_DONE) && !reload;
      if (load_done) begin
        cfg_out   <= cfg_new;
        cfg_valid <= 1'b1;
      end else if (state_q == S_DONE && reload) begin
        cfg_valid <= 1'b0;
      end
    end
  end

  // SRAM belongs to the core only once the config is loaded
  assign sram_addr = (state_q == S_DONE) ? core_sram_addr
                                         : BASE_ADDR + rd_off;
  assign sram_we   = (state_q == S_DONE) && core_sram_we;

endmodule
